// File: rtl/csr_pkg.sv
// csr_pkg: shared constants and types for the machine-mode CSR file.
//   - CSR addresses, interrupt cause codes, funct3 op encoding,
//     and bit positions inside mstatus/mie/mip.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    // funct12 of MRET (shares the SYSTEM opcode with the CSR ops)
    localparam logic [11:0] FUNCT12_MRET = 12'h302;

    localparam int          CAUSE_W   = 4;
    localparam logic [3:0]  CAUSE_MTI = 4'd7;
    localparam logic [3:0]  CAUSE_MEI = 4'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;  // same position as mip.MTIP
    localparam int MIE_MEIE     = 11; // same position as mip.MEIP

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_RW   = 3'b001,
        OP_RS   = 3'b010,
        OP_RC   = 3'b011,
        OP_RWI  = 3'b101,
        OP_RSI  = 3'b110,
        OP_RCI  = 3'b111
    } csr_op_e;

endpackage

// File: rtl/csr_irq_arbiter.sv
// csr_irq_arbiter: combinational interrupt pending / priority / cause.
//   i_gie    : mstatus.MIE
//   i_valid  : MW stage holds a real instruction
//   i_mie    : interrupt enable register
//   i_mip    : interrupt pending register
//   o_irq    : take an interrupt this cycle
//   o_cause  : cause code (external beats timer)
module csr_irq_arbiter
    import csr_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic               i_gie,
    input  logic               i_valid,
    input  logic [DW-1:0]      i_mie,
    input  logic [DW-1:0]      i_mip,
    output logic               o_irq,
    output logic [CAUSE_W-1:0] o_cause
);

    logic [DW-1:0] w_en;

    assign w_en    = i_mie & i_mip;
    assign o_irq   = i_gie & i_valid & (|w_en);
    assign o_cause = w_en[MIE_MEIE] ? CAUSE_MEI : CAUSE_MTI;

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file and trap unit.
//   Acts on the MW-stage instruction: CSR read/modify/write, timer and
//   external interrupt entry, and MRET. Drives a redirect (epc/epc_taken)
//   back to fetch.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   inst, valid        : MW-stage instruction and its valid flag
//   csr_we/csr_re/is_mret : decoder controls
//   wdata, pc          : rs1 value and PC of the MW instruction
//   timer_irq, ext_irq : level interrupt inputs (sampled into mip)
//   rdata              : old CSR value for rd
//   epc, epc_taken     : redirect target and flush strobe
// Optional: define CSR_MCYCLE_EN to add the 64-bit mcycle counter
//   (0xB00 low, 0xB80 high); undefined, both addresses read 0.
module csr_file
    import csr_pkg::*;
#(
    parameter int          DW        = 32,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] inst,
    input  logic          valid,
    input  logic          csr_we,
    input  logic          csr_re,
    input  logic          is_mret,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] pc,
    input  logic          timer_irq,
    input  logic          ext_irq,
    output logic [DW-1:0] rdata,
    output logic [DW-1:0] epc,
    output logic          epc_taken
);

    logic          r_mstatus_mie, r_mstatus_mpie;
    logic          r_mie_mtie, r_mie_meie;
    logic          r_mip_mtip, r_mip_meip;
    logic [DW-1:0] r_mtvec, r_mepc, r_mcause;

    logic [11:0]        w_addr;
    csr_op_e            w_op;
    logic [4:0]         w_zimm;
    logic [DW-1:0]      w_src, w_old, w_new;
    logic [DW-1:0]      w_mstatus, w_mie, w_mip;
    logic               w_irq, w_mret, w_wen, w_src0_skip;
    logic [CAUSE_W-1:0] w_cause;
    logic [DW-1:0]      w_base;
    logic               w_unused;

    assign w_addr   = inst[31:20];
    assign w_op     = csr_op_e'(inst[14:12]);
    assign w_zimm   = inst[19:15];
    assign w_unused = ^inst[11:0];

    // Immediate forms (funct3[2]) use the zero-extended rs1 field.
    assign w_src = inst[14] ? {{(DW-5){1'b0}}, w_zimm} : wdata;

    always_comb begin
        w_mstatus = '0;
        w_mstatus[MSTATUS_MIE]  = r_mstatus_mie;
        w_mstatus[MSTATUS_MPIE] = r_mstatus_mpie;
        w_mie = '0;
        w_mie[MIE_MTIE] = r_mie_mtie;
        w_mie[MIE_MEIE] = r_mie_meie;
        w_mip = '0;
        w_mip[MIE_MTIE] = r_mip_mtip;
        w_mip[MIE_MEIE] = r_mip_meip;
    end

    csr_irq_arbiter #(.DW(DW)) u_arb (
        .i_gie   (r_mstatus_mie),
        .i_valid (valid),
        .i_mie   (w_mie),
        .i_mip   (w_mip),
        .o_irq   (w_irq),
        .o_cause (w_cause)
    );

`ifdef CSR_MCYCLE_EN
    logic [63:0] r_mcycle;
`endif

    always_comb begin
        w_old = '0;
        case (w_addr)
            CSR_MSTATUS: w_old = w_mstatus;
            CSR_MIE:     w_old = w_mie;
            CSR_MTVEC:   w_old = r_mtvec;
            CSR_MEPC:    w_old = r_mepc;
            CSR_MCAUSE:  w_old = r_mcause;
            CSR_MIP:     w_old = w_mip;
`ifdef CSR_MCYCLE_EN
            CSR_MCYCLE:  w_old = DW'(r_mcycle[31:0]);
            CSR_MCYCLEH: w_old = DW'(r_mcycle[63:32]);
`endif
            default:     w_old = '0;
        endcase
    end

    always_comb begin
        w_new = w_old;
        case (w_op)
            OP_RW, OP_RWI: w_new = w_src;
            OP_RS, OP_RSI: w_new = w_old | w_src;
            OP_RC, OP_RCI: w_new = w_old & ~w_src;
            default:       w_new = w_old;
        endcase
    end

    // Set/clear with a zero source is a pure read.
    assign w_src0_skip = inst[13] & (w_zimm == 5'd0);
    // An interrupt squashes the MW instruction entirely.
    assign w_wen  = valid & csr_we & (inst[13:12] != 2'b00) & ~w_src0_skip & ~w_irq;
    assign w_mret = valid & is_mret & (w_addr == FUNCT12_MRET) & (inst[14:12] == 3'b000) & ~w_irq;

    assign rdata = (valid & csr_re & (inst[14:12] != 3'b000) & ~w_irq) ? w_old : '0;

    assign w_base    = {r_mtvec[DW-1:2], 2'b00};
    assign epc_taken = w_irq | w_mret;

    always_comb begin
        epc = '0;
        if (w_irq)
            epc = (r_mtvec[1:0] == 2'b01) ? w_base + DW'({w_cause, 2'b00}) : w_base;
        else if (w_mret)
            epc = r_mepc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_mtie     <= 1'b0;
            r_mie_meie     <= 1'b0;
            r_mip_mtip     <= 1'b0;
            r_mip_meip     <= 1'b0;
            r_mtvec        <= DW'(MTVEC_RST);
            r_mepc         <= '0;
            r_mcause       <= '0;
        end else begin
            r_mip_mtip <= timer_irq;
            r_mip_meip <= ext_irq;
            if (w_irq) begin
                r_mepc         <= {pc[DW-1:2], 2'b00};
                r_mcause       <= {1'b1, {(DW-1-CAUSE_W){1'b0}}, w_cause};
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (w_mret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_wen) begin
                case (w_addr)
                    CSR_MSTATUS: begin
                        r_mstatus_mie  <= w_new[MSTATUS_MIE];
                        r_mstatus_mpie <= w_new[MSTATUS_MPIE];
                    end
                    CSR_MIE: begin
                        r_mie_mtie <= w_new[MIE_MTIE];
                        r_mie_meie <= w_new[MIE_MEIE];
                    end
                    // Only direct (0) and vectored (1) modes are kept.
                    CSR_MTVEC:  r_mtvec  <= {w_new[DW-1:2], (w_new[1:0] == 2'b01) ? 2'b01 : 2'b00};
                    CSR_MEPC:   r_mepc   <= {w_new[DW-1:2], 2'b00};
                    CSR_MCAUSE: r_mcause <= w_new;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_MCYCLE_EN
    // A written half takes the new value; the counter does not advance
    // that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_mcycle <= '0;
        else if (w_wen && w_addr == CSR_MCYCLE)
            r_mcycle[31:0] <= w_new[31:0];
        else if (w_wen && w_addr == CSR_MCYCLEH)
            r_mcycle[63:32] <= w_new[31:0];
        else
            r_mcycle <= r_mcycle + 64'd1;
    end
`endif

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed vectors with a scoreboard queue; the stimulus
// pushes the expected {rdata, epc, epc_taken} per cycle and a monitor
// pops and compares on the falling edge.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = '0, wdata = '0, pc = '0;
    logic        valid = 1'b0, csr_we = 1'b0, csr_re = 1'b0, is_mret = 1'b0;
    logic        timer_irq = 1'b0, ext_irq = 1'b0;
    logic [31:0] rdata, epc;
    logic        epc_taken;

    always #5 clk = ~clk;

    csr_file #(.DW(32), .MTVEC_RST(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .valid     (valid),
        .csr_we    (csr_we),
        .csr_re    (csr_re),
        .is_mret   (is_mret),
        .wdata     (wdata),
        .pc        (pc),
        .timer_irq (timer_irq),
        .ext_irq   (ext_irq),
        .rdata     (rdata),
        .epc       (epc),
        .epc_taken (epc_taken)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [31:0] epc;
        logic        taken;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (rdata !== e.rdata || epc !== e.epc || epc_taken !== e.taken) begin
                n_bad++;
                $display("FAIL %s: got rdata=%h epc=%h taken=%b, want rdata=%h epc=%h taken=%b",
                         e.name, rdata, epc, epc_taken, e.rdata, e.epc, e.taken);
            end
        end
    end

    function automatic logic [31:0] ci(input logic [11:0] a, input logic [4:0] s, input logic [2:0] f);
        return {a, s, f, 5'd1, 7'h73};
    endfunction

    // Drive one cycle of MW-stage inputs and queue the expected outputs.
    task automatic step(input string nm, input logic [31:0] ins, input logic v, we, re, mr,
                        input logic [31:0] wd, pcv, er, ee, input logic et);
        exp_t e;
        inst = ins; valid = v; csr_we = we; csr_re = re; is_mret = mr;
        wdata = wd; pc = pcv;
        e.name = nm; e.rdata = er; e.epc = ee; e.taken = et;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Pure read: CSRRS with rs1 = x0.
    task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] ex);
        step(nm, ci(a, 5'd0, 3'b010), 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, ex, 32'h0, 1'b0);
    endtask

    task automatic wr(input string nm, input logic [11:0] a, input logic [2:0] f, input logic [4:0] s,
                      input logic [31:0] wd, input logic [31:0] ex_old);
        step(nm, ci(a, s, f), 1'b1, 1'b1, 1'b1, 1'b0, wd, 32'h0, ex_old, 32'h0, 1'b0);
    endtask

    task automatic idle(input string nm);
        step(nm, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    logic [31:0] mret_inst, wfi_inst;

    initial begin
        mret_inst = {12'h302, 5'd0, 3'b000, 5'd0, 7'h73};
        wfi_inst  = {12'h105, 5'd0, 3'b000, 5'd0, 7'h73};
        @(posedge clk);
        #1;

        // Reset state
        idle("rst_idle");
        rd("rst_mtvec", 12'h305, 32'h0);
        rst = 1'b0;

        // Basic RW and masking
        wr("t1_csrrw_mtvec", 12'h305, 3'b001, 5'd1, 32'h8000_0100, 32'h0);
        rd("t1_mtvec_rd", 12'h305, 32'h8000_0100);
        wr("mie_all", 12'h304, 3'b001, 5'd1, 32'hFFFF_FFFF, 32'h0);
        wr("mie_clr", 12'h304, 3'b011, 5'd2, 32'h0000_0800, 32'h0000_0880);
        rd("mie_rd", 12'h304, 32'h0000_0080);
        wr("mstatus_si", 12'h300, 3'b110, 5'd8, 32'h0, 32'h0);
        rd("mstatus_rd", 12'h300, 32'h0000_0008);

        // Timer interrupt, direct mode
        timer_irq = 1'b1;
        idle("irq_no_valid");
        timer_irq = 1'b0;
        step("t2_take", ci(12'h300, 5'd0, 3'b010), 1'b1, 1'b1, 1'b1, 1'b0,
             32'h0, 32'h40, 32'h0, 32'h8000_0100, 1'b1);
        rd("t2_mepc", 12'h341, 32'h0000_0040);
        rd("t2_mcause", 12'h342, 32'h8000_0007);
        rd("t2_mstatus", 12'h300, 32'h0000_0080);

        // MRET
        step("t4_mret", mret_inst, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h44, 32'h0, 32'h40, 1'b1);
        rd("t4_mstatus", 12'h300, 32'h0000_0088);

        // Interrupt squashes a same-cycle CSR write
        timer_irq = 1'b1;
        idle("t5_idle");
        timer_irq = 1'b0;
        step("t5_irq_vs_csrrw", ci(12'h305, 5'd1, 3'b001), 1'b1, 1'b1, 1'b1, 1'b0,
             32'h1234_5678, 32'h80, 32'h0, 32'h8000_0100, 1'b1);
        rd("t5_mtvec", 12'h305, 32'h8000_0100);
        rd("t5_mepc", 12'h341, 32'h0000_0080);

        // Vectored mode, both interrupts: external wins
        wr("t3_mtvec_vec", 12'h305, 3'b001, 5'd1, 32'h8000_0101, 32'h8000_0100);
        timer_irq = 1'b1;
        ext_irq   = 1'b1;
        wr("t3_mie_set", 12'h304, 3'b010, 5'd2, 32'h0000_0800, 32'h0000_0080);
        rd("t3_mip", 12'h344, 32'h0000_0880);
        // MIE set here only enables interrupts from the next cycle
        wr("t3_mstatus_si", 12'h300, 3'b110, 5'd8, 32'h0, 32'h0000_0080);
        timer_irq = 1'b0;
        ext_irq   = 1'b0;
        step("t3_take_ext", ci(12'h342, 5'd0, 3'b010), 1'b1, 1'b1, 1'b1, 1'b0,
             32'h0, 32'h100, 32'h0, 32'h8000_012C, 1'b1);
        rd("t3_mcause", 12'h342, 32'h8000_000B);
        rd("t3_mstatus", 12'h300, 32'h0000_0080);

        // Boundaries
        wr("unimpl_w", 12'h340, 3'b001, 5'd1, 32'h5, 32'h0);
        rd("unimpl_r", 12'h340, 32'h0);
        wr("mtvec_mode2", 12'h305, 3'b001, 5'd1, 32'h0000_0202, 32'h8000_0101);
        rd("mtvec_mode2_rd", 12'h305, 32'h0000_0200);
        wr("mepc_align", 12'h341, 3'b001, 5'd1, 32'h0000_0043, 32'h0000_0100);
        rd("mepc_rd", 12'h341, 32'h0000_0040);
        wr("csrrc_src0", 12'h304, 3'b011, 5'd0, 32'hFFFF_FFFF, 32'h0000_0880);
        rd("mie_kept", 12'h304, 32'h0000_0880);
        step("f3_zero", ci(12'h304, 5'd0, 3'b000), 1'b1, 1'b1, 1'b1, 1'b0,
             32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step("mret_bad_addr", wfi_inst, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Reset mid-handler
        rst = 1'b1;
        rd("t6_mtvec", 12'h305, 32'h0);
        rd("t6_mepc", 12'h341, 32'h0);
        rst = 1'b0;

`ifdef CSR_MCYCLE_EN
        rd("mcy_0", 12'hB00, 32'h0);
        idle("mcy_idle1");
        idle("mcy_idle2");
        rd("mcy_3", 12'hB00, 32'h3);
        wr("mcy_wr", 12'hB00, 3'b001, 5'd1, 32'hFFFF_FFFF, 32'h4);
        rd("mcyh_pre", 12'hB80, 32'h0);
        rd("mcyh_wrap", 12'hB80, 32'h1);
        rd("mcy_lo", 12'hB00, 32'h1);
`else
        rd("mcy_off_lo", 12'hB00, 32'h0);
        wr("mcy_off_w", 12'hB00, 3'b001, 5'd1, 32'hFFFF_FFFF, 32'h0);
        rd("mcy_off_hi", 12'hB80, 32'h0);
        rd("mcy_off_lo2", 12'hB00, 32'h0);
`endif

        rd("t6_mstatus", 12'h300, 32'h0);
        rd("t6_mcause", 12'h342, 32'h0);
        rd("t6_mie", 12'h304, 32'h0);

        idle("tail");
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
